// File: rtl/rib_uart_dump.sv
// rib_uart_dump
//   Memory read-back engine. On an accepted start it reads word_cnt_i
//   32-bit words over RIB beginning at base_addr_i (word aligned) and
//   streams each word out of tx_pin as four 8N1 frames, LSB byte first.
//   A single XOR checksum frame follows the last word.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start_i          one-cycle dump request, honoured only while idle
//   base_addr_i      first word address (bits [1:0] ignored)
//   word_cnt_i       number of words; zero completes immediately
//   busy_o / done_o  dump in progress / one-cycle completion pulse
//   req_o, we_o, addr_o, data_o, rdata_i, ready_i   RIB master (read only)
//   tx_pin           registered UART transmit line, idle high
module rib_uart_dump #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] rdata_i,
    input  logic        ready_i,
    output logic        tx_pin
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, REQ, SEND, CSUM, DONE} state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } rib_req_t;

    state_t        state, state_n;

    logic [31:0]   addr_q;
    logic [15:0]   cnt_q;
    logic [7:0]    csum_q;
    logic [31:0]   buf_q;
    logic [1:0]    byte_idx;
    logic [1:0]    nxt_idx;

    // Frame shifter: start bit goes straight to tx_q on load, the
    // remaining data+stop bits sit here and shift out LSB first.
    logic [8:0]    sh_q;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          tx_q;

    logic          tx_on;
    logic          frame_done;
    logic          ld;
    logic          ld_data;
    logic [7:0]    ld_byte;
    logic          word_end;

    rib_req_t      rib;

    assign tx_on      = (state == SEND) || (state == CSUM);
    assign frame_done = tx_on && (baud_cnt == BAUD_LAST) && (bit_cnt == 4'd9);
    assign nxt_idx    = byte_idx + 2'd1;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // ld starts a new frame at this edge; ld_data marks payload bytes,
    // which are folded into the checksum (the checksum frame is not).
    always_comb begin
        state_n  = state;
        ld       = 1'b0;
        ld_data  = 1'b0;
        ld_byte  = 8'h00;
        word_end = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_n = (word_cnt_i != 16'd0) ? REQ : DONE;
            end
            REQ: begin
                if (ready_i) begin
                    state_n = SEND;
                    ld      = 1'b1;
                    ld_data = 1'b1;
                    ld_byte = rdata_i[7:0];
                end
            end
            SEND: begin
                if (frame_done) begin
                    if (byte_idx != 2'd3) begin
                        ld      = 1'b1;
                        ld_data = 1'b1;
                        ld_byte = buf_q[{nxt_idx, 3'b000} +: 8];
                    end else begin
                        word_end = 1'b1;
                        if (cnt_q == 16'd1) begin
                            // Byte 3 was already XORed in at its load,
                            // so csum_q is final here.
                            state_n = CSUM;
                            ld      = 1'b1;
                            ld_byte = csum_q;
                        end else begin
                            state_n = REQ;
                        end
                    end
                end
            end
            CSUM: begin
                if (frame_done) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'h0;
            cnt_q    <= 16'h0;
            csum_q   <= 8'h00;
            buf_q    <= 32'h0;
            byte_idx <= 2'd0;
            sh_q     <= '1;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
        end else begin
            if (state == IDLE && start_i && word_cnt_i != 16'd0) begin
                addr_q <= base_addr_i & ~32'h3;
                cnt_q  <= word_cnt_i;
                csum_q <= 8'h00;
            end

            if (state == REQ && ready_i) buf_q <= rdata_i;

            if (state == REQ)  byte_idx <= 2'd0;
            else if (ld_data)  byte_idx <= nxt_idx;

            if (word_end) begin
                addr_q <= addr_q + 32'd4;
                cnt_q  <= cnt_q - 16'd1;
            end

            if (ld) begin
                tx_q     <= 1'b0;
                sh_q     <= {1'b1, ld_byte};
                bit_cnt  <= 4'd0;
                baud_cnt <= '0;
                if (ld_data) csum_q <= csum_q ^ ld_byte;
            end else if (tx_on) begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt <= '0;
                    if (bit_cnt == 4'd9) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q    <= sh_q[0];
                        sh_q    <= {1'b1, sh_q[8:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end else begin
                tx_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        rib      = '0;
        rib.req  = (state == REQ);
        rib.addr = addr_q;
    end

    assign req_o  = rib.req;
    assign we_o   = rib.we;
    assign addr_o = rib.addr;
    assign data_o = rib.data;
    assign busy_o = (state == REQ) || (state == SEND) || (state == CSUM);
    assign done_o = (state == DONE);
    assign tx_pin = tx_q;

endmodule
